// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Bundle of the fetch stage's instruction-memory handshake, decode handshake
// and next-PC control signals.
//   imem_req/imem_addr   fetch request and address (fetch unit -> memory)
//   imem_ack/imem_rdata  request completion and instruction word (memory -> fetch unit)
//   instr_valid/decode_ready  decode handshake
//   instr/opcode/func/pc_out  instruction presented to the decoder
//   PC_sel/cmp_true/rs_data   next-PC control from the decoder and datapath
//   misalign             sticky jr-target misalignment flag
//   instr_count          retired-instruction counter
// Modports: master = fetch unit side, slave = memory/decoder side.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             instr_valid;
    logic             decode_ready;
    logic [31:0]      instr;
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic [31:0]      pc_out;
    logic [1:0]       PC_sel;
    logic             cmp_true;
    logic [31:0]      rs_data;
    logic             misalign;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, func, pc_out,
               misalign, instr_count,
        input  imem_ack, imem_rdata, decode_ready, PC_sel, cmp_true, rs_data
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, func, pc_out,
               misalign, instr_count,
        output imem_ack, imem_rdata, decode_ready, PC_sel, cmp_true, rs_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake,
// latches the word into an instruction register, presents it to the decoder
// with a valid/ready handshake and computes the next PC on retirement.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   if_fetch_unit_if.master (memory, decode and next-PC signals)
// Parameters:
//   RESET_PC  PC loaded on reset
//   CNT_W     width of the retired-instruction counter
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rstn,
    if_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_pc_out;
    logic [31:0]      r_instr;
    logic             r_misalign;
    logic [CNT_W-1:0] r_count;

    logic             w_capture;
    logic             w_retire;
    logic [31:0]      w_pc4;
    logic [31:0]      w_br_off;
    logic [31:0]      w_next_pc;
    logic             w_jr_misalign;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs. imem_req is a pure decode of the
    // state register: S_FETCH only launches the request, so the request is
    // seen from the first edge after reset onwards (while in S_WAIT).
    always_comb begin
        w_state_nxt     = r_state;
        w_capture       = 1'b0;
        w_retire        = 1'b0;
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                bus.instr_valid = 1'b1;
                if (bus.decode_ready) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Next-PC selection from the held instruction and its address
    always_comb begin
        w_pc4         = r_pc_out + 32'd4;
        w_br_off      = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        w_next_pc     = w_pc4;
        w_jr_misalign = 1'b0;
        case (bus.PC_sel)
            2'b00: w_next_pc = w_pc4;
            2'b01: w_next_pc = bus.cmp_true ? (w_pc4 + w_br_off) : w_pc4;
            2'b10: w_next_pc = {w_pc4[31:28], r_instr[25:0], 2'b00};
            2'b11: begin
                w_next_pc     = {bus.rs_data[31:2], 2'b00};
                w_jr_misalign = (bus.rs_data[1:0] != 2'b00);
            end
            default: w_next_pc = w_pc4;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc       <= RESET_PC;
            r_pc_out   <= RESET_PC;
            r_instr    <= '0;
            r_misalign <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_capture) begin
                r_instr  <= bus.imem_rdata;
                r_pc_out <= r_pc;
            end
            if (w_retire) begin
                r_pc    <= w_next_pc;
                r_count <= r_count + CNT_ONE;
                if (w_jr_misalign) begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.opcode      = r_instr[31:26];
    assign bus.func        = r_instr[5:0];
    assign bus.pc_out      = r_pc_out;
    assign bus.misalign    = r_misalign;
    assign bus.instr_count = r_count;

endmodule
